mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIRST_GRANT, default 0: the requester index that wins the first arbitration after reset.
REQ-002 SHALL have port CLK  in  1  clock; all logic on the rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports Mn_SEND_ADDR_VALID / Mn_SEND_ADDR  in  1/32  request address from requester n (n=0,1).
REQ-005 SHALL have ports Mn_SEND_DATA_VALID / Mn_SEND_DATA  in  1/32  write data; valid together with address means write.
REQ-006 SHALL have port Mn_SEND_READY  out  1  address/data accepted for requester n.
REQ-007 SHALL have ports Mn_RECEIVE_VALID / Mn_RECEIVE_DATA  out  1/32  response to requester n.
REQ-008 SHALL have port Mn_RECEIVE_READY  in  1  requester n can take a response.
REQ-009 SHALL have ports MEM_SEND_ADDR_VALID / MEM_SEND_ADDR  out  1/32  address to memory or cache.
REQ-010 SHALL have ports MEM_SEND_DATA_VALID / MEM_SEND_DATA  out  1/32  write data to memory.
REQ-011 SHALL have port MEM_SEND_READY  in  1  memory accepted the address beat.
REQ-012 SHALL have ports MEM_RECEIVE_VALID / MEM_RECEIVE_DATA  in  1/32  memory response; exactly one per transaction, reads and writes alike.
REQ-013 SHALL have port MEM_RECEIVE_READY  out  1  arbiter forwards the response.
REQ-014 SHALL have port GRANT  out  2  one-hot owner of the memory port; 2'b00 when idle.

Function
REQ-015 SHALL implement a registered FSM with states S_IDLE=2'b00, S_ADDR=2'b01 and S_RESP=2'b10; encoding 2'b11 SHALL return to S_IDLE.
REQ-016 SHALL, in S_IDLE with at least one Mn_SEND_ADDR_VALID high, register the winner into GRANT and enter S_ADDR on the next edge.
REQ-017 SHALL arbitrate round-robin: when both requesters are valid, the requester not in last_grant wins; a single valid requester always wins.
REQ-018 SHALL update last_grant only when a transaction completes, in S_RESP on the response handshake.
REQ-019 SHALL, in S_ADDR, drive MEM_SEND_* combinationally from the granted requester's SEND_* inputs, and drive Mg_SEND_READY = MEM_SEND_READY for the granted requester only.
REQ-020 SHALL hold every non-granted Mn_SEND_READY at 0 in all states, and all MEM_SEND_*_VALID at 0 outside S_ADDR.
REQ-021 SHALL leave S_ADDR for S_RESP on the edge where MEM_SEND_ADDR_VALID && MEM_SEND_READY.
REQ-022 SHALL, in S_RESP, drive Mg_RECEIVE_VALID = MEM_RECEIVE_VALID and Mg_RECEIVE_DATA = MEM_RECEIVE_DATA for the granted requester, and MEM_RECEIVE_READY = Mg_RECEIVE_READY.
REQ-023 SHALL, on the S_RESP handshake, clear GRANT and return to S_IDLE.
REQ-024 SHALL hold MEM_RECEIVE_READY at 0 outside S_RESP, and hold non-granted Mn_RECEIVE_VALID at 0.
REQ-025 SHALL drive non-granted Mn_RECEIVE_DATA at 32'b0.
REQ-026 SHALL give a minimum latency of 1 cycle from Mn_SEND_ADDR_VALID in S_IDLE to MEM_SEND_ADDR_VALID.
REQ-027 SHALL insert exactly one S_IDLE cycle between back-to-back transactions.
REQ-028 SHALL ignore a request that drops in S_ADDR before its handshake: remain in S_ADDR holding the grant, because requesters hold valid until ready.
REQ-029 SHALL keep a multi-word burst from one requester (e.g. six sequential reads) fair: the other requester is granted between words when it is waiting.

Reset
REQ-030 SHALL, while RST is high, set STATE=S_IDLE, GRANT=2'b00 and last_grant so that FIRST_GRANT wins next; all combinational VALID/READY outputs SHALL then be 0.
REQ-031 SHALL, on reset mid-transaction, abandon the transaction; a response arriving after reset SHALL NOT be forwarded, since MEM_RECEIVE_READY=0 in S_IDLE.

Verification
REQ-032 Bench SHALL cover: M0 read addr 0x100, MEM_SEND_READY=1, response 0xDEADBEEF one cycle later -> MEM_SEND_ADDR=0x100 one cycle after request, M0_RECEIVE_DATA=0xDEADBEEF, GRANT 01 then 00.
REQ-033 Bench SHALL cover: M0 and M1 both valid from reset with FIRST_GRANT=0 -> order M0, M1, M0, M1 over four transactions, one idle cycle between each.
REQ-034 Bench SHALL cover: M1 write addr 0x40, data 0x12345678 -> MEM_SEND_DATA_VALID=1 and MEM_SEND_DATA=0x12345678 in the same cycle as the address; the ack response is routed to M1 only.
REQ-035 Bench SHALL cover: MEM_SEND_READY held low 5 cycles, then M0_RECEIVE_READY held low 3 cycles -> the arbiter stalls in S_ADDR and then S_RESP, with no grant change and M1_SEND_READY=0 throughout.
REQ-036 Bench SHALL cover: RST asserted in S_RESP, then MEM_RECEIVE_VALID pulsed -> GRANT=00, M0/M1_RECEIVE_VALID=0, MEM_RECEIVE_READY=0.
REQ-037 Bench SHALL cover: M0 issues six sequential reads while M1 is valid throughout -> grants interleave M0, M1, M0, … and every response matches its own address.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and grant signals of the two-port memory arbiter
interface mem_arbiter_if;
    logic        M0_SEND_ADDR_VALID;
    logic [31:0] M0_SEND_ADDR;
    logic        M0_SEND_DATA_VALID;
    logic [31:0] M0_SEND_DATA;
    logic        M0_SEND_READY;
    logic        M0_RECEIVE_VALID;
    logic [31:0] M0_RECEIVE_DATA;
    logic        M0_RECEIVE_READY;

    logic        M1_SEND_ADDR_VALID;
    logic [31:0] M1_SEND_ADDR;
    logic        M1_SEND_DATA_VALID;
    logic [31:0] M1_SEND_DATA;
    logic        M1_SEND_READY;
    logic        M1_RECEIVE_VALID;
    logic [31:0] M1_RECEIVE_DATA;
    logic        M1_RECEIVE_READY;

    logic        MEM_SEND_ADDR_VALID;
    logic [31:0] MEM_SEND_ADDR;
    logic        MEM_SEND_DATA_VALID;
    logic [31:0] MEM_SEND_DATA;
    logic        MEM_SEND_READY;
    logic        MEM_RECEIVE_VALID;
    logic [31:0] MEM_RECEIVE_DATA;
    logic        MEM_RECEIVE_READY;

    logic [1:0]  GRANT;

    // Arbiter side.
    modport slave (
        input  M0_SEND_ADDR_VALID, M0_SEND_ADDR, M0_SEND_DATA_VALID, M0_SEND_DATA, M0_RECEIVE_READY,
        output M0_SEND_READY, M0_RECEIVE_VALID, M0_RECEIVE_DATA,
        input  M1_SEND_ADDR_VALID, M1_SEND_ADDR, M1_SEND_DATA_VALID, M1_SEND_DATA, M1_RECEIVE_READY,
        output M1_SEND_READY, M1_RECEIVE_VALID, M1_RECEIVE_DATA,
        output MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA, MEM_RECEIVE_READY,
        input  MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        output GRANT
    );

    // Requester/memory environment side.
    modport master (
        output M0_SEND_ADDR_VALID, M0_SEND_ADDR, M0_SEND_DATA_VALID, M0_SEND_DATA, M0_RECEIVE_READY,
        input  M0_SEND_READY, M0_RECEIVE_VALID, M0_RECEIVE_DATA,
        output M1_SEND_ADDR_VALID, M1_SEND_ADDR, M1_SEND_DATA_VALID, M1_SEND_DATA, M1_RECEIVE_READY,
        input  M1_SEND_READY, M1_RECEIVE_VALID, M1_RECEIVE_DATA,
        input  MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA, MEM_RECEIVE_READY,
        output MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        input  GRANT
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single memory port
module mem_arbiter #(
    parameter int FIRST_GRANT = 0
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // last_grant holds the index of the previous winner; the other side wins a tie.
    localparam logic LAST_INIT = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_last;

    logic w_any_req;
    logic w_win;
    logic w_addr_hs;
    logic w_resp_hs;

    assign w_any_req = bus.M0_SEND_ADDR_VALID || bus.M1_SEND_ADDR_VALID;
    assign w_addr_hs = bus.MEM_SEND_ADDR_VALID && bus.MEM_SEND_READY;
    assign w_resp_hs = bus.MEM_RECEIVE_VALID && bus.MEM_RECEIVE_READY;
    assign bus.GRANT = r_grant;

    always_comb begin
        w_win = 1'b0;
        if (bus.M0_SEND_ADDR_VALID && bus.M1_SEND_ADDR_VALID) begin
            w_win = ~r_last;
        end else if (bus.M1_SEND_ADDR_VALID) begin
            w_win = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_last  <= LAST_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_addr_hs) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_last  <= r_grant[1];
                        r_grant <= 2'b00;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Steering decodes the one-hot grant so a non-granted side never sees a ready or valid.
    always_comb begin
        bus.MEM_SEND_ADDR_VALID = 1'b0;
        bus.MEM_SEND_ADDR       = 32'b0;
        bus.MEM_SEND_DATA_VALID = 1'b0;
        bus.MEM_SEND_DATA       = 32'b0;
        bus.MEM_RECEIVE_READY   = 1'b0;
        bus.M0_SEND_READY       = 1'b0;
        bus.M0_RECEIVE_VALID    = 1'b0;
        bus.M0_RECEIVE_DATA     = 32'b0;
        bus.M1_SEND_READY       = 1'b0;
        bus.M1_RECEIVE_VALID    = 1'b0;
        bus.M1_RECEIVE_DATA     = 32'b0;
        if (r_state == S_ADDR) begin
            if (r_grant == 2'b01) begin
                bus.MEM_SEND_ADDR_VALID = bus.M0_SEND_ADDR_VALID;
                bus.MEM_SEND_ADDR       = bus.M0_SEND_ADDR;
                bus.MEM_SEND_DATA_VALID = bus.M0_SEND_DATA_VALID;
                bus.MEM_SEND_DATA       = bus.M0_SEND_DATA;
                bus.M0_SEND_READY       = bus.MEM_SEND_READY;
            end else if (r_grant == 2'b10) begin
                bus.MEM_SEND_ADDR_VALID = bus.M1_SEND_ADDR_VALID;
                bus.MEM_SEND_ADDR       = bus.M1_SEND_ADDR;
                bus.MEM_SEND_DATA_VALID = bus.M1_SEND_DATA_VALID;
                bus.MEM_SEND_DATA       = bus.M1_SEND_DATA;
                bus.M1_SEND_READY       = bus.MEM_SEND_READY;
            end
        end
        if (r_state == S_RESP) begin
            if (r_grant == 2'b01) begin
                bus.M0_RECEIVE_VALID  = bus.MEM_RECEIVE_VALID;
                bus.M0_RECEIVE_DATA   = bus.MEM_RECEIVE_DATA;
                bus.MEM_RECEIVE_READY = bus.M0_RECEIVE_READY;
            end else if (r_grant == 2'b10) begin
                bus.M1_RECEIVE_VALID  = bus.MEM_RECEIVE_VALID;
                bus.M1_RECEIVE_DATA   = bus.MEM_RECEIVE_DATA;
                bus.MEM_RECEIVE_READY = bus.M1_RECEIVE_READY;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic        who;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } exp_addr_t;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_rsp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();
    mem_arbiter #(.FIRST_GRANT(0)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    logic [1:0]  req_av;
    logic [1:0]  req_dv;
    logic [31:0] req_a [2];
    logic [31:0] req_d [2];
    logic [1:0]  rrdy;
    logic        mem_sr;
    logic        mem_rv;
    logic [31:0] mem_rd;

    logic [1:0]  sready;
    assign sready = {bus.M1_SEND_READY, bus.M0_SEND_READY};

    assign bus.M0_SEND_ADDR_VALID = req_av[0];
    assign bus.M0_SEND_ADDR       = req_a[0];
    assign bus.M0_SEND_DATA_VALID = req_dv[0];
    assign bus.M0_SEND_DATA       = req_d[0];
    assign bus.M0_RECEIVE_READY   = rrdy[0];
    assign bus.M1_SEND_ADDR_VALID = req_av[1];
    assign bus.M1_SEND_ADDR       = req_a[1];
    assign bus.M1_SEND_DATA_VALID = req_dv[1];
    assign bus.M1_SEND_DATA       = req_d[1];
    assign bus.M1_RECEIVE_READY   = rrdy[1];
    assign bus.MEM_SEND_READY     = mem_sr;
    assign bus.MEM_RECEIVE_VALID  = mem_rv;
    assign bus.MEM_RECEIVE_DATA   = mem_rd;

    req_t      rq0[$];
    req_t      rq1[$];
    exp_addr_t addr_q[$];
    exp_rsp_t  rsp_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic        stall_go;
    int          stall_len;
    logic        man_mode;
    logic        man_rv;
    logic [31:0] man_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic who, input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic [31:0] rsp);
        addr_q.push_back('{who: who, addr: addr, wr: wr, data: data});
        rsp_q.push_back('{who: who, data: rsp});
    endtask

    task automatic push_req(input int n, input logic [31:0] addr, input logic wr, input logic [31:0] data);
        if (n == 0) rq0.push_back('{addr: addr, wr: wr, data: data});
        else        rq1.push_back('{addr: addr, wr: wr, data: data});
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if (rq0.size() == 0 && rq1.size() == 0 && req_av == 2'b00 &&
                addr_q.size() == 0 && rsp_q.size() == 0 && bus.GRANT == 2'b00) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_done: traffic still pending after %0d cycles (addr_q=%0d rsp_q=%0d)",
                 max_cycles, addr_q.size(), rsp_q.size());
    endtask

    function automatic logic [31:0] rsp_for(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : a + 32'h1000_0000;
    endfunction

    // Requesters: hold valid until the send handshake, then present the next queued request.
    initial begin
        logic [1:0] hs;
        req_t e;
        req_av = 2'b00;
        req_dv = 2'b00;
        req_a[0] = '0; req_a[1] = '0; req_d[0] = '0; req_d[1] = '0;
        forever begin
            @(negedge CLK);
            hs = req_av & sready;
            @(posedge CLK);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (!req_av[n] || hs[n]) begin
                    if (n == 0 && rq0.size() > 0) begin
                        e = rq0.pop_front();
                        req_av[n] = 1'b1; req_a[n] = e.addr; req_dv[n] = e.wr; req_d[n] = e.data;
                    end else if (n == 1 && rq1.size() > 0) begin
                        e = rq1.pop_front();
                        req_av[n] = 1'b1; req_a[n] = e.addr; req_dv[n] = e.wr; req_d[n] = e.data;
                    end else begin
                        req_av[n] = 1'b0; req_dv[n] = 1'b0;
                    end
                end
            end
        end
    end

    // Memory: one response per accepted address, in the cycle after the address beat.
    initial begin
        logic a_hs, av, r_hs, cap_w, seen_go;
        logic [31:0] cap_a;
        int stall_cnt;
        mem_sr = 1'b1; mem_rv = 1'b0; mem_rd = '0; seen_go = 1'b0; stall_cnt = 0;
        forever begin
            @(negedge CLK);
            a_hs  = bus.MEM_SEND_ADDR_VALID && bus.MEM_SEND_READY;
            av    = bus.MEM_SEND_ADDR_VALID;
            r_hs  = bus.MEM_RECEIVE_VALID && bus.MEM_RECEIVE_READY;
            cap_a = bus.MEM_SEND_ADDR;
            cap_w = bus.MEM_SEND_DATA_VALID;
            @(posedge CLK);
            #1;
            if (man_mode) begin
                mem_sr = 1'b1; mem_rv = man_rv; mem_rd = man_rd;
            end else begin
                if (stall_go != seen_go) begin
                    seen_go = stall_go; stall_cnt = stall_len;
                end else if (av && !a_hs && stall_cnt > 0) begin
                    stall_cnt--;
                end
                mem_sr = (stall_cnt == 0);
                if (r_hs) mem_rv = 1'b0;
                if (a_hs) begin
                    mem_rv = 1'b1;
                    mem_rd = cap_w ? 32'h0000_ACC0 : rsp_for(cap_a);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks steering invariants.
    initial begin
        logic prev_rhs, prev_req_idle;
        exp_addr_t ea;
        exp_rsp_t  er;
        prev_rhs = 1'b0; prev_req_idle = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_rhs = 1'b0; prev_req_idle = 1'b0;
            end else begin
                if (prev_rhs) chk("idle_after_txn", bus.GRANT, 2'b00);
                if (prev_req_idle) chk("grant_after_idle", bus.GRANT != 2'b00, 1'b1);
                if (bus.GRANT != 2'b00) begin
                    chk("m0_ready_gate", bus.M0_SEND_READY & ~bus.GRANT[0], 1'b0);
                    chk("m1_ready_gate", bus.M1_SEND_READY & ~bus.GRANT[1], 1'b0);
                end
                if (bus.MEM_SEND_ADDR_VALID && bus.MEM_SEND_READY) begin
                    if (addr_q.size() == 0) begin
                        chk("unexpected_addr", bus.MEM_SEND_ADDR, 32'hFFFF_FFFF);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("addr_grant", bus.GRANT, ea.who ? 2'b10 : 2'b01);
                        chk("addr_value", bus.MEM_SEND_ADDR, ea.addr);
                        chk("addr_data_valid", bus.MEM_SEND_DATA_VALID, ea.wr);
                        if (ea.wr) chk("addr_wdata", bus.MEM_SEND_DATA, ea.data);
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    logic v, ov;
                    logic [31:0] d, od;
                    v  = (n == 0) ? bus.M0_RECEIVE_VALID : bus.M1_RECEIVE_VALID;
                    d  = (n == 0) ? bus.M0_RECEIVE_DATA  : bus.M1_RECEIVE_DATA;
                    ov = (n == 0) ? bus.M1_RECEIVE_VALID : bus.M0_RECEIVE_VALID;
                    od = (n == 0) ? bus.M1_RECEIVE_DATA  : bus.M0_RECEIVE_DATA;
                    if (v && rrdy[n]) begin
                        if (rsp_q.size() == 0) begin
                            chk("unexpected_rsp", d, 32'hFFFF_FFFF);
                        end else begin
                            er = rsp_q.pop_front();
                            chk("rsp_owner", n[0], er.who);
                            chk("rsp_data", d, er.data);
                            chk("rsp_other_valid", ov, 1'b0);
                            chk("rsp_other_data", od, 32'h0);
                        end
                    end
                end
                prev_rhs = bus.MEM_RECEIVE_VALID && bus.MEM_RECEIVE_READY;
                prev_req_idle = (bus.GRANT == 2'b00) && (req_av != 2'b00);
            end
        end
    end

    initial begin
        #300000;
        miscompares++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        bit found;
        RST = 1'b1; rrdy = 2'b11;
        stall_go = 1'b0; stall_len = 0;
        man_mode = 1'b0; man_rv = 1'b0; man_rd = '0;

        // Both requesters valid out of reset: M0, M1, M0, M1.
        @(negedge CLK);
        push_req(0, 32'h10, 1'b0, 32'h0); push_req(0, 32'h14, 1'b0, 32'h0);
        push_req(1, 32'h20, 1'b0, 32'h0); push_req(1, 32'h24, 1'b0, 32'h0);
        expect_txn(1'b0, 32'h10, 1'b0, 32'h0, 32'h1000_0010);
        expect_txn(1'b1, 32'h20, 1'b0, 32'h0, 32'h1000_0020);
        expect_txn(1'b0, 32'h14, 1'b0, 32'h0, 32'h1000_0014);
        expect_txn(1'b1, 32'h24, 1'b0, 32'h0, 32'h1000_0024);
        repeat (2) @(negedge CLK);
        chk("rst_grant", bus.GRANT, 2'b00);
        chk("rst_mem_addr_valid", bus.MEM_SEND_ADDR_VALID, 1'b0);
        chk("rst_mem_data_valid", bus.MEM_SEND_DATA_VALID, 1'b0);
        chk("rst_mem_rcv_ready", bus.MEM_RECEIVE_READY, 1'b0);
        chk("rst_send_ready", {bus.M1_SEND_READY, bus.M0_SEND_READY}, 2'b00);
        chk("rst_rcv_valid", {bus.M1_RECEIVE_VALID, bus.M0_RECEIVE_VALID}, 2'b00);
        @(posedge CLK); #1;
        RST = 1'b0;
        wait_done(200);

        // Single M0 read of 0x100, cycle-exact timing.
        @(negedge CLK);
        push_req(0, 32'h100, 1'b0, 32'h0);
        expect_txn(1'b0, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            found = req_av[0];
        end
        chk("lat_req_seen", found, 1'b1);
        chk("lat_idle_grant", bus.GRANT, 2'b00);
        chk("lat_idle_addr_valid", bus.MEM_SEND_ADDR_VALID, 1'b0);
        @(negedge CLK);
        chk("lat_addr_valid", bus.MEM_SEND_ADDR_VALID, 1'b1);
        chk("lat_addr", bus.MEM_SEND_ADDR, 32'h100);
        chk("lat_grant", bus.GRANT, 2'b01);
        @(negedge CLK);
        chk("lat_rsp_valid", bus.M0_RECEIVE_VALID, 1'b1);
        chk("lat_rsp_data", bus.M0_RECEIVE_DATA, 32'hDEADBEEF);
        @(negedge CLK);
        chk("lat_grant_clear", bus.GRANT, 2'b00);
        wait_done(50);

        // M1 write: data beat alongside address, ack routed to M1.
        @(negedge CLK);
        push_req(1, 32'h40, 1'b1, 32'h1234_5678);
        expect_txn(1'b1, 32'h40, 1'b1, 32'h1234_5678, 32'h0000_ACC0);
        wait_done(50);

        // Address stall of 5 cycles, then response stall of 3 cycles, M1 waiting.
        @(negedge CLK);
        stall_len = 5; stall_go = ~stall_go; rrdy[0] = 1'b0;
        push_req(0, 32'h200, 1'b0, 32'h0);
        expect_txn(1'b0, 32'h200, 1'b0, 32'h0, 32'h1000_0200);
        expect_txn(1'b1, 32'h300, 1'b0, 32'h0, 32'h1000_0300);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            found = (bus.GRANT == 2'b01);
        end
        chk("stall_granted", found, 1'b1);
        push_req(1, 32'h300, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            chk("stall_addr_grant", bus.GRANT, 2'b01);
            chk("stall_addr_m1_ready", bus.M1_SEND_READY, 1'b0);
            chk("stall_addr_mem_ready", bus.MEM_SEND_READY, 1'b0);
            chk("stall_addr_valid", bus.MEM_SEND_ADDR_VALID, 1'b1);
        end
        @(negedge CLK);
        chk("stall_addr_release", bus.MEM_SEND_READY, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_rsp_grant", bus.GRANT, 2'b01);
            chk("stall_rsp_valid", bus.M0_RECEIVE_VALID, 1'b1);
            chk("stall_rsp_mem_ready", bus.MEM_RECEIVE_READY, 1'b0);
            chk("stall_rsp_m1_ready", bus.M1_SEND_READY, 1'b0);
        end
        @(posedge CLK); #1;
        rrdy[0] = 1'b1;
        wait_done(50);

        // Reset while waiting for a response; a late response must not be forwarded.
        @(negedge CLK);
        man_mode = 1'b1; man_rv = 1'b0; man_rd = 32'h0;
        push_req(0, 32'h500, 1'b0, 32'h0);
        addr_q.push_back('{who: 1'b0, addr: 32'h500, wr: 1'b0, data: 32'h0});
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            found = (bus.GRANT == 2'b01);
        end
        chk("rst_txn_granted", found, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; man_rv = 1'b1; man_rd = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("midrst_grant", bus.GRANT, 2'b00);
            chk("midrst_rcv_valid", {bus.M1_RECEIVE_VALID, bus.M0_RECEIVE_VALID}, 2'b00);
            chk("midrst_mem_rcv_ready", bus.MEM_RECEIVE_READY, 1'b0);
        end
        man_rv = 1'b0;
        @(negedge CLK);
        man_mode = 1'b0;
        repeat (2) @(negedge CLK);

        // Six-word M0 burst against a continuously waiting M1.
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            push_req(0, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            push_req(1, 32'h2000 + 32'(4 * i), 1'b0, 32'h0);
            expect_txn(1'b0, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 32'h1000_1000 + 32'(4 * i));
            expect_txn(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 32'h1000_2000 + 32'(4 * i));
        end
        wait_done(300);

        chk("end_addr_q_empty", addr_q.size(), 32'd0);
        chk("end_rsp_q_empty", rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
